// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32i fetch stage.
// MISALIGN_TRAP_EN adds the HALT state used by the misaligned-target trap.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_KILL = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_t;
`else
  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_KILL = 3'd3
  } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_unit_adder32.sv
// 32-bit wrap-around adder used for PC+4.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_unit_if_id_pipeline_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load/bubble.
module if_id_pipeline_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load_valid,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;

  // Next IF/ID contents; bubbles and flushes leave the PC fields untouched.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (load_valid) begin
        valid_d = 1'b1;
        instr_d = load_instr;
        pc_d    = load_pc;
        pc4_d   = load_pc4;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32i fetch stage: PC owner, IMEM req/ack master, IF/ID loader.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect -> HALT).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Branch_Taken_E,
  input  logic [31:0] PC_Target_E,
  input  logic        Stall_F,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Ack,
  input  logic [31:0] IMEM_Data,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_Plus4_D,
  output logic        Valid_D,
  output logic        Fetch_Busy,
  output logic        Misaligned_F
);

`ifdef MISALIGN_TRAP_EN
  localparam fetch_state_t TRAP_STATE = ST_HALT;
`else
  localparam fetch_state_t TRAP_STATE = ST_REQ;
`endif

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_q, redirect_d;
  logic [31:0]  skid_q, skid_d;
  logic         mis_q, mis_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  tgt;
  logic         tgt_mis;
  logic         ld_valid;
  logic [31:0]  ld_instr;

  adder32 u_pc_adder (
    .a   (pc_q),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  // Redirect target conditioning: trap on low bits, or force word alignment.
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    tgt     = PC_Target_E;
    tgt_mis = |PC_Target_E[1:0];
`else
    tgt     = PC_Target_E & 32'hFFFF_FFFC;
    tgt_mis = 1'b0;
`endif
  end

  // Fetch FSM next-state, PC steering and IF/ID load selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    skid_d     = skid_q;
    mis_d      = mis_q;
    ld_valid   = 1'b0;
    ld_instr   = IMEM_Data;
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (IMEM_Ack) begin
          if (Branch_Taken_E) begin
            pc_d  = tgt;
            mis_d = mis_q | tgt_mis;
            state_d = tgt_mis ? TRAP_STATE : ST_REQ;
          end else if (Stall_F) begin
            skid_d  = IMEM_Data;
            state_d = ST_HOLD;
          end else begin
            ld_valid = 1'b1;
            ld_instr = IMEM_Data;
            pc_d     = pc_plus4;
          end
        end else if (Branch_Taken_E) begin
          redirect_d = tgt;
          mis_d      = mis_q | tgt_mis;
          state_d    = ST_KILL;
        end
      end
      ST_HOLD: begin
        if (Branch_Taken_E) begin
          pc_d    = tgt;
          mis_d   = mis_q | tgt_mis;
          state_d = tgt_mis ? TRAP_STATE : ST_REQ;
        end else if (!Stall_F) begin
          ld_valid = 1'b1;
          ld_instr = skid_q;
          pc_d     = pc_plus4;
          state_d  = ST_REQ;
        end
      end
      ST_KILL: begin
        // Latest redirect wins, including one arriving with the ack.
        if (Branch_Taken_E) begin
          redirect_d = tgt;
          mis_d      = mis_q | tgt_mis;
        end
        if (IMEM_Ack) begin
          pc_d    = redirect_d;
          state_d = mis_d ? TRAP_STATE : ST_REQ;
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= '0;
      skid_q     <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      skid_q     <= skid_d;
      mis_q      <= mis_d;
    end
  end

  if_id_pipeline_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (CLK),
    .rst        (RST),
    .flush      (Branch_Taken_E),
    .stall      (Stall_F),
    .load_valid (ld_valid),
    .load_instr (ld_instr),
    .load_pc    (pc_q),
    .load_pc4   (pc_plus4),
    .valid      (Valid_D),
    .instr      (Instr_D),
    .pc         (PC_D),
    .pc4        (PC_Plus4_D)
  );

  assign IMEM_Req     = (state_q == ST_REQ) || (state_q == ST_KILL);
  assign IMEM_Addr    = pc_q;
  assign Fetch_Busy   = (state_q == ST_BOOT) || (state_q == ST_KILL) ||
                        ((state_q == ST_REQ) && !IMEM_Ack);
  assign Misaligned_F = mis_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage of the RV32i pipeline. It owns the program counter and issues word fetches to instruction memory over a request/acknowledge handshake. It loads the IF/ID pipeline register. It consumes Execute's Branch_Taken_E / PC_Target_E redirect to steer the PC and flush wrong-path instructions, while honouring hazard-unit stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC value fetched first after reset
- NOP_INSTR, 32'h0000_0013, encoding injected into IF/ID on bubbles (addi x0,x0,0)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- Branch_Taken_E  in  1  redirect request from Execute
- PC_Target_E  in  32  redirect target from Execute
- Stall_F  in  1  hazard unit: hold PC and IF/ID
- IMEM_Req  out  1  fetch request valid
- IMEM_Addr  out  32  fetch word address (PC)
- IMEM_Ack  in  1  response valid; may assert the same cycle as IMEM_Req
- IMEM_Data  in  32  instruction word, valid with IMEM_Ack
- Instr_D, PC_D, PC_Plus4_D  out  32 each  IF/ID contents
- Valid_D  out  1  IF/ID holds a real instruction
- Fetch_Busy  out  1  high in BOOT, KILL, or REQ without ack
- Misaligned_F  out  1  sticky misaligned-target flag (macro only)

## Operation
- Handshake: once IMEM_Req rises, IMEM_Req and IMEM_Addr stay stable until the IMEM_Ack cycle. A request completes in the cycle IMEM_Ack=1. At most one request is outstanding.
- FSM states are BOOT, REQ, HOLD, KILL, plus HALT (macro only).
- BOOT: IMEM_Req=0. Always goes to REQ next cycle.
- REQ: IMEM_Req=1, IMEM_Addr=PC.
  - Ack, no redirect, no stall: IF/ID <= {IMEM_Data, PC, PC+4}, Valid_D=1, PC <= PC+4. Stay in REQ.
  - Ack with Stall_F: data goes to skid register, PC unchanged, go to HOLD.
  - Ack with Branch_Taken_E: discard data, PC <= target, stay in REQ.
  - No ack with Branch_Taken_E: Redirect_PC <= target, go to KILL.
- HOLD: IMEM_Req=0.
  - Stall_F falls: skid loads into IF/ID, PC <= PC+4, go to REQ.
  - Branch_Taken_E: discard skid, PC <= target, go to REQ.
- KILL: keep requesting the old address.
  - On ack: discard data, PC <= Redirect_PC, go to REQ.
  - A further Branch_Taken_E overwrites Redirect_PC (latest wins). If it coincides with the ack, the new target is used.
- IF/ID update rules, in priority order:
  1. Branch_Taken_E: flush, i.e. Valid_D=0 and Instr_D=NOP_INSTR. This wins over Stall_F.
  2. Stall_F: hold all IF/ID contents.
  3. Otherwise: load the delivered instruction, or a bubble if none was delivered.
- PC arithmetic is mod 2^32. PC 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - PC = RESET_PC; state = BOOT.
  - IMEM_Req = 0; IMEM_Addr = RESET_PC.
  - Valid_D = 0; Instr_D = NOP_INSTR; PC_D = 0; PC_Plus4_D = 0.
  - Fetch_Busy = 1; Misaligned_F = 0.
- RST asserted mid-request abandons the outstanding request. A late IMEM_Ack while in BOOT is ignored.
- First IMEM_Req is the cycle after reset deasserts. With a zero-wait memory, the first Valid_D comes 2 cycles after reset deasserts.
- Throughput: one instruction per cycle with zero-wait memory. Instruction appears in IF/ID the cycle after its ack.
- Redirect penalty: the target's request is issued the cycle after Branch_Taken_E (REQ or HOLD). In KILL it is issued the cycle after the pending ack.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A redirect with PC_Target_E[1:0]≠0 sets Misaligned_F (sticky until RST) and enters HALT.
  - HALT: no requests; IF/ID holds bubbles; only RST exits.
  - If a request is outstanding, HALT is entered after its ack.
- MISALIGN_TRAP_EN undefined: PC_Target_E[1:0] is forced to 2'b00. Misaligned_F is tied 0 and HALT does not exist.

## Structure
- Package definitions holds the fetch_state_t enum and the NOP_INSTR default constant.
- Sub-module if_id_pipeline_reg holds the IF/ID register with its flush, stall and load priority.
- The PC+4 computation uses the existing adder32.

## Test plan
- Reset, zero-wait memory returning addr-as-data → IMEM_Addr sequence 0,4,8. Instr_D=0 with Valid_D=1 two cycles after reset deasserts, then 4, 8.
- Stall_F high for 3 cycles over an ack at PC=8 → IF/ID frozen, IMEM_Req=0 in HOLD. The instruction at 8 appears in IF/ID the cycle after Stall_F falls, then fetch resumes at 12.
- Memory acking at 3-cycle latency; Branch_Taken_E with target 0x100 in wait cycle 1 → IMEM_Addr stays 0x8 until ack, that data is discarded, next IMEM_Addr=0x100, Valid_D=0 throughout.
- Branch_Taken_E and Stall_F high in the same cycle → Valid_D=0, Instr_D=0x00000013.
- PC=32'hFFFF_FFFC acked → next IMEM_Addr=0x0.
- MISALIGN_TRAP_EN: target 0x102 → Misaligned_F=1, IMEM_Req stays 0 until RST. Without the macro, next IMEM_Addr=0x100.
